// File: rtl/sha_result_scanner_if.sv
// Bus bundle between the SHA lane array / host side and sha_result_scanner.
// The master drives batch data and FIFO pops; the slave reports scan status and found nonces.
interface sha_result_scanner_if #(
  parameter int NUM_LANES  = 10,
  parameter int LANE_IDX_W = 4,
  parameter int HASH_W     = 256,
  parameter int NONCE_W    = 32
);
  logic                          start;
  logic [NONCE_W-1:0]            base_nonce;
  logic [NUM_LANES*HASH_W-1:0]   lane_hash;
  logic [HASH_W-1:0]             target;
  logic                          clear;
  logic                          busy;
  logic                          done;
  logic                          found_valid;
  logic [NONCE_W-1:0]            found_nonce;
  logic                          found_pop;
  logic [LANE_IDX_W-1:0]         fifo_count;
  logic                          overflow;

  modport master (
    output start, base_nonce, lane_hash, target, clear, found_pop,
    input  busy, done, found_valid, found_nonce, fifo_count, overflow
  );

  modport slave (
    input  start, base_nonce, lane_hash, target, clear, found_pop,
    output busy, done, found_valid, found_nonce, fifo_count, overflow
  );
endinterface

// File: rtl/sha_result_scanner.sv
// Scans a captured batch of SHA lane digests against a target, one lane per cycle,
// queueing winning nonces in a small FIFO. Optional macro SCAN_EARLY_EXIT_EN stops at the first hit.
module sha_result_scanner #(
  parameter int NUM_LANES  = 10,
  parameter int LANE_IDX_W = 4,
  parameter int HASH_W     = 256,
  parameter int NONCE_W    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  sha_result_scanner_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state;
  logic [LANE_IDX_W-1:0] laneCnt;
  logic                  busyReg;
  logic                  doneReg;

  logic [HASH_W-1:0]     laneHashReg [NUM_LANES];
  logic [HASH_W-1:0]     targetReg;
  logic [NONCE_W-1:0]    baseNonceReg;

  logic [NONCE_W-1:0]    fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [LANE_IDX_W-1:0] fifoCount;
  logic                  overflowReg;
  logic [NONCE_W-1:0]    headReg;

  logic                  captureEn;
  logic                  laneHit;
  logic                  lastLane;
  logic                  scanEnd;
  logic                  pushReq;
  logic [NONCE_W-1:0]    pushData;
  logic                  fifoFull;
  logic                  doPush;
  logic                  doPop;
  logic                  dropHit;
  logic [LANE_IDX_W-1:0] nextCount;
  logic [PTR_W-1:0]      nextRd;
  logic [NONCE_W-1:0]    nextHead;

  assign captureEn = (state == IDLE) && bus.start && !bus.clear;
  assign laneHit   = laneHashReg[laneCnt] < targetReg;
  assign lastLane  = laneCnt == LANE_IDX_W'(NUM_LANES - 1);

`ifdef SCAN_EARLY_EXIT_EN
  assign scanEnd = lastLane || laneHit;
`else
  assign scanEnd = lastLane;
`endif

  // Batch data registers carry no reset; they are only meaningful once captured.
  always_ff @(posedge clk) begin
    if (captureEn) begin
      targetReg    <= bus.target;
      baseNonceReg <= bus.base_nonce;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gLane
      always_ff @(posedge clk) begin
        if (captureEn) begin
          laneHashReg[gi] <= bus.lane_hash[gi*HASH_W +: HASH_W];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      laneCnt <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else if (bus.clear) begin
      state   <= IDLE;
      laneCnt <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          if (bus.start) begin
            state   <= SCAN;
            laneCnt <= '0;
            busyReg <= 1'b1;
          end
        end
        SCAN: begin
          if (scanEnd) begin
            state   <= DONE;
            doneReg <= 1'b1;
          end else begin
            laneCnt <= laneCnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          doneReg <= 1'b0;
          busyReg <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          doneReg <= 1'b0;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign pushReq  = (state == SCAN) && laneHit && !bus.clear;
  assign pushData = baseNonceReg + NONCE_W'(laneCnt);
  assign fifoFull = fifoCount == LANE_IDX_W'(FIFO_DEPTH);
  assign doPop    = (fifoCount != '0) && bus.found_pop && !bus.clear;
  // A full FIFO still accepts a hit when the head is popped in the same cycle.
  assign doPush   = pushReq && (!fifoFull || doPop);
  assign dropHit  = pushReq && fifoFull && !doPop;

  always_comb begin
    nextCount = fifoCount + LANE_IDX_W'(doPush) - LANE_IDX_W'(doPop);
    nextRd    = doPop ? rdPtr + 1'b1 : rdPtr;
    nextHead  = '0;
    if (nextCount != '0) begin
      // The new head may be the entry being written this very cycle.
      if (doPush && (nextRd == wrPtr)) begin
        nextHead = pushData;
      end else begin
        nextHead = fifoMem[nextRd];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoMem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      overflowReg <= 1'b0;
      headReg     <= '0;
    end else if (bus.clear) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      overflowReg <= 1'b0;
      headReg     <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      rdPtr     <= nextRd;
      fifoCount <= nextCount;
      headReg   <= nextHead;
      if (dropHit) begin
        overflowReg <= 1'b1;
      end
    end
  end

  assign bus.busy        = busyReg;
  assign bus.done        = doneReg;
  assign bus.found_valid = fifoCount != '0;
  assign bus.found_nonce = headReg;
  assign bus.fifo_count  = fifoCount;
  assign bus.overflow    = overflowReg;
endmodule

// File: tb/tb_sha_result_scanner.sv
// Directed bench for sha_result_scanner: single/multi hit, overflow, full push+pop,
// nonce wrap, equality, reset abort and clear/start collision.
module tb_sha_result_scanner;
  localparam int NUM_LANES  = 10;
  localparam int LANE_IDX_W = 4;
  localparam int HASH_W     = 256;
  localparam int NONCE_W    = 32;
  localparam int FIFO_DEPTH = 4;
`ifdef SCAN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [HASH_W-1:0] ALL_ONES = {HASH_W{1'b1}};
  localparam logic [HASH_W-1:0] HIT_HASH = 256'd1;
  localparam logic [HASH_W-1:0] TGT      = {8'h00, {248{1'b1}}};

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic sawDone;

  always #5 clk = ~clk;

  sha_result_scanner_if #(
    .NUM_LANES(NUM_LANES), .LANE_IDX_W(LANE_IDX_W), .HASH_W(HASH_W), .NONCE_W(NONCE_W)
  ) bus ();

  sha_result_scanner #(
    .NUM_LANES(NUM_LANES), .LANE_IDX_W(LANE_IDX_W), .HASH_W(HASH_W),
    .NONCE_W(NONCE_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLanes(input logic [NUM_LANES-1:0] hitMask);
    for (int i = 0; i < NUM_LANES; i++) begin
      bus.lane_hash[i*HASH_W +: HASH_W] = hitMask[i] ? HIT_HASH : ALL_ONES;
    end
  endtask

  // Leaves the bench in cycle T+1 of the batch.
  task automatic pulseStart(input logic [NONCE_W-1:0] base);
    bus.base_nonce = base;
    bus.target     = TGT;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Returns cycle index of done relative to start edge (T+1 counts as 1); bounded.
  task automatic waitDone(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic popOne();
    bus.found_pop = 1'b1;
    tick();
    bus.found_pop = 1'b0;
  endtask

  task automatic pulseClear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.found_pop  = 1'b0;
    bus.base_nonce = '0;
    bus.target     = TGT;
    setLanes('0);
    rst = 1'b1;
    tick();
    tick();
    checkEq("rst_busy",   64'(bus.busy), 64'd0);
    checkEq("rst_done",   64'(bus.done), 64'd0);
    checkEq("rst_valid",  64'(bus.found_valid), 64'd0);
    checkEq("rst_nonce",  64'(bus.found_nonce), 64'd0);
    checkEq("rst_count",  64'(bus.fifo_count), 64'd0);
    checkEq("rst_ovf",    64'(bus.overflow), 64'd0);
    rst = 1'b0;
    tick();

    // Single hit on lane 7; inputs changed after capture must not matter.
    setLanes(10'b0010000000);
    pulseStart(32'h100);
    bus.lane_hash = '0;
    bus.target    = ALL_ONES;
    checkEq("single_busy_t1", 64'(bus.busy), 64'd1);
    repeat (7) tick();
    checkEq("single_valid_t8", 64'(bus.found_valid), 64'd0);
    tick();
    checkEq("single_valid_t9", 64'(bus.found_valid), 64'd1);
    checkEq("single_nonce_t9", 64'(bus.found_nonce), 64'h107);
    checkEq("single_count_t9", 64'(bus.fifo_count), 64'd1);
    tick();
    checkEq("single_done_t10", 64'(bus.done), 64'd0);
    tick();
    checkEq("single_done_t11", 64'(bus.done), 64'(!EARLY));
    tick();
    checkEq("single_busy_t12", 64'(bus.busy), 64'd0);
    checkEq("single_count_end", 64'(bus.fifo_count), 64'd1);
    popOne();
    checkEq("single_pop_valid", 64'(bus.found_valid), 64'd0);
    checkEq("single_pop_nonce", 64'(bus.found_nonce), 64'd0);
    popOne();
    checkEq("empty_pop_count", 64'(bus.fifo_count), 64'd0);

    // Multi-hit: lanes 2, 5, 9 with base 0.
    setLanes(10'b1000100100);
    pulseStart(32'h0);
    waitDone(lat);
    checkEq("multi_latency", 64'(lat), EARLY ? 64'd4 : 64'd11);
    tick();
    checkEq("multi_count", 64'(bus.fifo_count), EARLY ? 64'd1 : 64'd3);
    checkEq("multi_head0", 64'(bus.found_nonce), 64'd2);
    popOne();
    if (!EARLY) begin
      checkEq("multi_head1", 64'(bus.found_nonce), 64'd5);
      popOne();
      checkEq("multi_head2", 64'(bus.found_nonce), 64'd9);
      popOne();
    end
    checkEq("multi_empty", 64'(bus.found_valid), 64'd0);
    checkEq("multi_ovf", 64'(bus.overflow), 64'd0);

`ifndef SCAN_EARLY_EXIT_EN
    // Overflow: every lane hits, nobody pops.
    setLanes('1);
    pulseStart(32'h50);
    waitDone(lat);
    checkEq("ovf_latency", 64'(lat), 64'd11);
    tick();
    checkEq("ovf_count", 64'(bus.fifo_count), 64'd4);
    checkEq("ovf_flag", 64'(bus.overflow), 64'd1);
    checkEq("ovf_head0", 64'(bus.found_nonce), 64'h50);
    popOne();
    checkEq("ovf_head1", 64'(bus.found_nonce), 64'h51);
    checkEq("ovf_count_pop", 64'(bus.fifo_count), 64'd3);
    popOne();
    checkEq("ovf_head2", 64'(bus.found_nonce), 64'h52);
    checkEq("ovf_sticky", 64'(bus.overflow), 64'd1);
    pulseClear();
    checkEq("clr_count", 64'(bus.fifo_count), 64'd0);
    checkEq("clr_ovf", 64'(bus.overflow), 64'd0);
    checkEq("clr_nonce", 64'(bus.found_nonce), 64'd0);

    // Fill exactly, then scan all-hit with pop held high: push+pop each cycle.
    setLanes(10'b0000001111);
    pulseStart(32'h200);
    waitDone(lat);
    tick();
    checkEq("full_count", 64'(bus.fifo_count), 64'd4);
    checkEq("full_ovf", 64'(bus.overflow), 64'd0);
    setLanes('1);
    pulseStart(32'h300);
    bus.found_pop = 1'b1;
    for (int k = 1; k <= NUM_LANES; k++) begin
      tick();
      checkEq($sformatf("pp_count_c%0d", k + 1), 64'(bus.fifo_count), 64'd4);
    end
    bus.found_pop = 1'b0;
    checkEq("pp_done", 64'(bus.done), 64'd1);
    checkEq("pp_ovf", 64'(bus.overflow), 64'd0);
    checkEq("pp_head", 64'(bus.found_nonce), 64'h306);
    tick();
    pulseClear();
`endif

    // Nonce wrap on lane 3; lane 5 digest equal to target must not hit.
    setLanes(10'b0000001000);
    bus.lane_hash[5*HASH_W +: HASH_W] = TGT;
    pulseStart(32'hFFFF_FFFE);
    waitDone(lat);
    tick();
    checkEq("wrap_count", 64'(bus.fifo_count), 64'd1);
    checkEq("wrap_nonce", 64'(bus.found_nonce), 64'h1);
    popOne();

    // Asynchronous reset mid-scan.
    setLanes(10'b0000000001);
    pulseStart(32'h10);
    tick();
    tick();
    checkEq("abort_pre_count", 64'(bus.fifo_count), 64'd1);
    tick();
    rst = 1'b1;
    #1;
    checkEq("abort_busy",  64'(bus.busy), 64'd0);
    checkEq("abort_done",  64'(bus.done), 64'd0);
    checkEq("abort_valid", 64'(bus.found_valid), 64'd0);
    checkEq("abort_nonce", 64'(bus.found_nonce), 64'd0);
    checkEq("abort_count", 64'(bus.fifo_count), 64'd0);
    tick();
    rst = 1'b0;
    sawDone = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      sawDone = sawDone | bus.done | bus.busy;
    end
    checkEq("abort_no_done", 64'(sawDone), 64'd0);

    // clear and start together: clear wins.
    setLanes('1);
    bus.base_nonce = 32'h77;
    bus.clear = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    checkEq("clrstart_busy", 64'(bus.busy), 64'd0);
    repeat (3) tick();
    checkEq("clrstart_count", 64'(bus.fifo_count), 64'd0);
    checkEq("clrstart_busy2", 64'(bus.busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
